// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parametrised register file.
// Holds the clear-engine state encoding used by the FSM and the top.
package reg_file_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Sequential clear engine: sweeps one entry per cycle and gates writes.
// Ports: clk, reset (sync, active-low), clr_req in; clr_busy, clr_done,
// rg_wrt_rdy, clr_we and clr_addr (clear write port) out.
module reg_file_clr_fsm
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              rg_wrt_rdy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      clr_we   = 1'b0;
      clr_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            clr_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            // Last entry: finish here, the pointer never wraps.
            // A reset landing on this cycle suppresses the done pulse.
            if (&ptr_q) begin
               clr_done = reset;
               state_d  = IDLE;
               ptr_d    = '0;
            end
         end
      endcase
   end

   assign clr_addr   = ptr_q;
   assign rg_wrt_rdy = (state_q == IDLE);
   assign clr_busy   = (state_q == CLEAR);

endmodule

// File: rtl/reg_file_param.sv
// Parametrised GPR file: NUM_RD combinational read ports, one write port,
// optional hardwired-zero entry 0, optional write bypass, clear engine.
// Ports: clk, reset (sync, active-low), rg_wrt_en/addr/data in, rg_wrt_rdy
// out; packed rg_rd_addr in / rg_rd_data out; clr_req in, clr_busy/done out.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rg_wrt_en,
   input  logic [ADDR_W-1:0]        rg_wrt_addr,
   input  logic [DATA_W-1:0]        rg_wrt_data,
   output logic                     rg_wrt_rdy,
   input  logic [NUM_RD*ADDR_W-1:0] rg_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rg_rd_data,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_acc;
   logic              wr_zero;

   reg_file_clr_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clr_fsm (
      .clk        (clk),
      .reset      (reset),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .rg_wrt_rdy (rg_wrt_rdy),
      .clr_we     (clr_we),
      .clr_addr   (clr_addr)
   );

   assign wr_acc  = rg_wrt_en & rg_wrt_rdy & reset;
   assign wr_zero = (ZERO_REG != 0) && (rg_wrt_addr == '0);

   // Clear and user writes never overlap: rdy is low while sweeping.
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[clr_addr] = '0;
      end else if (wr_acc && !wr_zero) begin
         mem_d[rg_wrt_addr] = rg_wrt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;

      assign ra = rg_rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rv = mem_q[ra];
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rv = '0;
         end else if ((BYPASS != 0) && wr_acc && (ra == rg_wrt_addr)) begin
            rv = rg_wrt_data;
         end
      end

      assign rg_rd_data[k*DATA_W +: DATA_W] = rv;
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised plus directed bench for reg_file_param (bypass on and off).
// Both instances share stimulus and are compared to one array model.
module tb_reg_file_param;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [NR*AW-1:0] rd_addr;
   logic             clr_req;

   logic             rdy_a, busy_a, done_a;
   logic             rdy_b, busy_b, done_b;
   logic [NR*DW-1:0] rd_a, rd_b;

   reg_file_param #(
      .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR),
      .ZERO_REG (1), .BYPASS (1)
   ) dut_a (
      .clk (clk), .reset (reset),
      .rg_wrt_en (wr_en), .rg_wrt_addr (wr_addr),
      .rg_wrt_data (wr_data), .rg_wrt_rdy (rdy_a),
      .rg_rd_addr (rd_addr), .rg_rd_data (rd_a),
      .clr_req (clr_req), .clr_busy (busy_a), .clr_done (done_a)
   );

   reg_file_param #(
      .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR),
      .ZERO_REG (1), .BYPASS (0)
   ) dut_b (
      .clk (clk), .reset (reset),
      .rg_wrt_en (wr_en), .rg_wrt_addr (wr_addr),
      .rg_wrt_data (wr_data), .rg_wrt_rdy (rdy_b),
      .rg_rd_addr (rd_addr), .rg_rd_data (rd_b),
      .clr_req (clr_req), .clr_busy (busy_b), .clr_done (done_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain array, a busy flag and a count of entries
   // already wiped by the current sweep.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_valid = 0;
   bit            m_busy  = 0;
   int            m_cnt   = 0;
   int            done_seen = 0;
   int            busy_seen = 0;

   task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(int a, bit byp);
      if (a == 0) return '0;
      if (byp && reset && wr_en && !m_busy && a == int'(wr_addr))
         return wr_data;
      return m_mem[a];
   endfunction

   task automatic cycle();
      int a;
      @(negedge clk);
      if (m_valid) begin
         check("rdy_a", rdy_a, !m_busy);
         check("rdy_b", rdy_b, !m_busy);
         check("busy_a", busy_a, m_busy);
         check("busy_b", busy_b, m_busy);
         check("done_a", done_a, m_busy && m_cnt == DEPTH-1 && reset);
         check("done_b", done_b, m_busy && m_cnt == DEPTH-1 && reset);
         for (int k = 0; k < NR; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            check($sformatf("rd%0d_byp a=%0d", k, a),
                  rd_a[k*DW +: DW], exp_rd(a, 1));
            check($sformatf("rd%0d_nobyp a=%0d", k, a),
                  rd_b[k*DW +: DW], exp_rd(a, 0));
         end
         if (done_a) done_seen++;
         if (busy_a) busy_seen++;
      end
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_busy  = 0;
         m_cnt   = 0;
         m_valid = 1;
      end else if (m_busy) begin
         m_mem[m_cnt] = '0;
         m_cnt++;
         if (m_cnt == DEPTH) m_busy = 0;
      end else begin
         if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
         if (clr_req) begin
            m_busy = 1;
            m_cnt  = 0;
         end
      end
      #1;
   endtask

   task automatic wr(int a, logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      cycle();
      wr_en   = 1'b0;
   endtask

   task automatic rd(int a0, int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) begin
         rd(i, DEPTH-1-i);
         cycle();
      end
   endtask

   initial begin
      bit acc;
      int n;

      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      clr_req = 1'b0;

      // Reset for two cycles, with a write that must be dropped.
      wr_en   = 1'b1;
      wr_addr = 5'd4;
      wr_data = 32'hFFFF_0000;
      cycle();
      cycle();
      wr_en = 1'b0;
      reset = 1'b1;
      read_all();

      // Plain write/read, and the hardwired zero entry.
      wr(5, 32'hDEAD_BEEF);
      rd(5, 5);
      cycle();
      check("addr5", rd_a[DW-1:0], 32'hDEAD_BEEF);
      wr(0, 32'h1234);
      rd(0, 0);
      cycle();
      check("addr0", rd_a[DW-1:0], 32'h0);

      // Same-cycle bypass on port 1.
      wr(7, 32'h1111_2222);
      rd(0, 7);
      #1;
      wr_en   = 1'b1;
      wr_addr = 5'd7;
      wr_data = 32'hA5A5_A5A5;
      #1;
      check("byp_on", rd_a[2*DW-1:DW], 32'hA5A5_A5A5);
      check("byp_off", rd_b[2*DW-1:DW], 32'h1111_2222);
      cycle();
      wr_en = 1'b0;

      // Full sweep with a writer stalled behind it.
      for (int i = 1; i < DEPTH; i++) wr(i, DW'(i));
      rd(3, 20);
      busy_seen = 0;
      done_seen = 0;
      clr_req   = 1'b1;
      cycle();
      clr_req = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 5'd9;
      wr_data = 32'h55;
      n = 0;
      do begin
         if (n == 10) begin
            check("sw10_a3", rd_a[DW-1:0], 32'h0);
            check("sw10_a20", rd_a[2*DW-1:DW], 32'd20);
         end
         acc = !m_busy;
         cycle();
         n++;
      end while (!acc && n < 60);
      wr_en = 1'b0;
      check("stall_acc", DW'(acc), 32'd1);
      check("busy_cycles", DW'(busy_seen), 32'd32);
      check("done_pulses", DW'(done_seen), 32'd1);
      rd(9, 9);
      #1;
      check("addr9", rd_a[DW-1:0], 32'h55);
      read_all();

      // Reset landing on cycle 12 of a sweep.
      for (int i = 1; i < DEPTH; i++) wr(i, $urandom);
      done_seen = 0;
      clr_req   = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int i = 1; i < 12; i++) cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      #1;
      check("mid_busy", DW'(busy_a), 32'd0);
      check("mid_rdy", DW'(rdy_a), 32'd1);
      check("mid_done", DW'(done_seen), 32'd0);
      read_all();

      // Random traffic, with occasional clears and resets.
      for (int c = 0; c < 600; c++) begin
         wr_en   = ($urandom % 3) != 0;
         wr_addr = AW'($urandom);
         wr_data = $urandom;
         if ($urandom % 4 == 0)
            rd(int'(wr_addr), $urandom % DEPTH);
         else
            rd($urandom % DEPTH, $urandom % DEPTH);
         clr_req = ($urandom % 50) == 0;
         reset   = ($urandom % 150) != 0;
         cycle();
      end
      wr_en   = 1'b0;
      clr_req = 1'b0;
      reset   = 1'b1;
      for (int c = 0; c < 40; c++) cycle();
      read_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised general-purpose register file, successor to the fixed 32x32 two-read-port file in the datapath.
- Adds configurable width, depth and read-port count, an optional hardwired-zero entry 0, and optional write-to-read bypass.
- Adds a sequential clear engine: one entry per cycle, with a write-ready handshake.
- Sits between decode (read addresses) and writeback (write port) in the CPU datapath.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a read of the address being written this cycle returns rg_wrt_data

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous reset, active-low (reset==0 resets)
rg_wrt_en  in  1  write request
rg_wrt_addr  in  ADDR_W  write address
rg_wrt_data  in  DATA_W  write data
rg_wrt_rdy  out  1  write accepted this cycle when high
rg_rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rg_rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
clr_req  in  1  start a sequential clear of all entries
clr_busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse on the last clear write

Behaviour:
- Reset (clk edge with reset==0):
  - All entries become 0; FSM goes to IDLE; clear pointer becomes 0.
  - clr_busy=0, clr_done=0, rg_wrt_rdy=1 after that edge.
  - Writes presented while reset==0 are discarded.
- Reads are combinational (zero latency) from the array:
  - ZERO_REG=1 and address 0: read returns 0.
  - BYPASS=1, write accepted this cycle, and rg_wrt_addr == read address: read returns rg_wrt_data, except address 0 when ZERO_REG=1.
  - BYPASS=0: read returns the old value until the edge.
- Write handshake:
  - rg_wrt_rdy = (state==IDLE).
  - A write is accepted when rg_wrt_en && rg_wrt_rdy && reset==1; the entry updates on that edge.
  - When rg_wrt_rdy=0 the writer must hold its request; nothing is queued.
  - With ZERO_REG=1, a write to address 0 is accepted (rdy high) but has no effect.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req: pointer set to 0, clr_busy=1 from the next cycle.
  - If a write and clr_req occur in the same IDLE cycle, the write is performed first, then the sweep starts.
  - CLEAR: each cycle writes 0 to entry[pointer] and increments the pointer.
  - When the pointer reaches DEPTH-1, that write completes, clr_done pulses high for that cycle, and the FSM returns to IDLE; rg_wrt_rdy=1 the following cycle.
  - Sweep length is exactly DEPTH cycles.
  - clr_req during CLEAR is ignored, with no restart.
- Reads during CLEAR return current contents: entries below the pointer read 0, the rest read old data.
- Pointer width is ADDR_W; no wrap past DEPTH-1, because the FSM exits there.
- Reset mid-sweep: array zeroed immediately, FSM returns to IDLE, no clr_done pulse.
- Outputs have no X after the first reset edge. The array contents before the first reset are undefined.

Decomposition:
- Shared package reg_file_pkg:
  - state enum (IDLE=1'b0, CLEAR=1'b1).
  - Default width constants DATA_W_DEF=32, ADDR_W_DEF=5.
- One sub-module, reg_file_clr_fsm: owns state, pointer, clr_busy, clr_done and rg_wrt_rdy. It outputs the clear write enable and address, which are muxed with the user write port in the top.
- Read ports are generated with a for-generate over NUM_RD.

Test Plan:
- Reset: drive reset=0 for 2 cycles, release, read all 32 addresses on both ports -> all return 0; rg_wrt_rdy=1, clr_busy=0.
- Write/read: write 32'hDEADBEEF to addr 5; next cycle read port0=5, port1=5 -> both return 32'hDEADBEEF. Write 32'h1234 to addr 0 -> read addr 0 returns 0.
- Bypass: write 32'hA5A5A5A5 to addr 7 while port1 reads addr 7 in the same cycle -> port1 shows 32'hA5A5A5A5 combinationally (BYPASS=1). Repeat with BYPASS=0 -> port1 shows the old value.
- Clear sweep:
  - Fill addr 1..31 with their index, pulse clr_req.
  - clr_busy high for 32 cycles, rg_wrt_rdy low for the same 32 cycles.
  - At cycle 10 of the sweep, addr 3 reads 0 and addr 20 reads 20.
  - clr_done pulses once on the 32nd cycle; afterwards all entries read 0.
- Write stall: assert rg_wrt_en addr 9 data 32'h55 during the sweep and hold it -> ignored until rg_wrt_rdy=1, then accepted; addr 9 reads 32'h55.
- Reset mid-sweep: assert reset=0 on cycle 12 of the sweep -> next cycle state IDLE, clr_busy=0, no clr_done, all entries 0.
